spi_master_reader: RTL and testbench
====================================

Name: spi_master_reader

Overview:
- SPI mode-0 master that reads back the byte stream served by our FPGA-side SPI slave (memory/JPEG buffer readout).
- One transaction:
  - Asserts ssel.
  - Sends one 8-bit address byte.
  - Clocks in rd_len data bytes.
  - Presents each data byte on a one-cycle valid strobe.
- Used as the bench/bridge counterpart of the slave and as a loopback readout path on-chip.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; legal range 2..255.
- LEN_W, 16: width of rd_len and of the internal byte counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE; ignored while busy=1.
- addr  in  8  address byte, latched on an accepted start.
- rd_len  in  LEN_W  number of bytes to read, latched on an accepted start. 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- rx_data  out  8  last received byte. Valid while rx_valid=1; holds its value otherwise.
- rx_valid  out  1  one-cycle pulse per received data byte.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out, MSB first.
- ssel  out  1  SPI select, active low, idle high.
- miso  in  1  SPI data in. Sampled directly, with no synchronizer; slave timing guarantees stability at the sample point.

Behaviour:
- Reset (async, reset_n=0):
  - ssel=1, sclk=0, mosi=0, busy=0, done=0, rx_valid=0, rx_data=0x00.
  - FSM returns to IDLE.
  - Reset mid-transaction aborts immediately; no done pulse.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP. All outputs are registered.
- IDLE:
  - On start=1, latch addr and rd_len, load the shift register with addr.
  - Set the bit counter to 8*(rd_len+1) total bits; go to SETUP.
- SETUP:
  - ssel=0, sclk=0, mosi=addr[7].
  - Lasts CLK_DIV cycles, then go to XFER with sclk driven high.
- XFER, per bit:
  - sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - On the clk edge that drives sclk 0->1, sample miso into rx_shift (shift left, LSB in).
  - On the clk edge that drives sclk 1->0, update mosi to the next bit.
  - mosi sequence: addr[6..0] for the address byte, then constant 0 for all data bytes.
- Byte boundaries:
  - After the 8th rising edge of each byte, excluding the address byte, the next cycle has rx_data = the completed byte and rx_valid=1 for exactly one cycle.
  - Bytes received during the address byte are discarded.
- End of XFER:
  - After the falling edge that ends the last bit, go to HOLD.
  - The last bit in XFER has no trailing low phase; HOLD provides it.
- HOLD: ssel=0, sclk=0 for CLK_DIV cycles. Then ssel=1; go to GAP.
- GAP:
  - ssel=1, busy=1 for CLK_DIV cycles.
  - Then done=1 for one cycle, busy=0, go to IDLE.
  - done and busy deassert on the same edge.
- Timing totals:
  - A new start is accepted in the cycle done is high or any later cycle.
  - Total busy time = CLK_DIV*(1 + 2*8*(rd_len+1) - 1 + 1 + 1) cycles.
  - sclk rising edges = exactly 8*(rd_len+1).
- rd_len=0: address byte only; no rx_valid pulses; done still pulses.
- rd_len at max (all ones): the counter must not overflow. Internal bit counter width is LEN_W+4.
- start asserted while busy: no effect. Latched addr/rd_len are unchanged.
- start held high continuously: a new transaction starts each time IDLE is re-entered.
- Received bytes are never dropped: rx_valid has no backpressure, and the consumer must accept each byte.

Test Plan:
- Reset mid-XFER (after 5 sclk rises) -> ssel=1, sclk=0, busy=0 asynchronously; no done; next start (addr=0x01, rd_len=1) completes normally.
- CLK_DIV=4, addr=0xA5, rd_len=0 -> mosi bits 1,0,1,0,0,1,0,1 at 8 rising edges; no rx_valid; done after 4*(1+15+1+1)=72 busy cycles; ssel high 4 cycles before done.
- CLK_DIV=4, addr=0x10, rd_len=3, slave model returns 0x3C,0xFF,0x00 -> three rx_valid pulses with rx_data 0x3C,0xFF,0x00 in order; mosi=0 through data bytes; 32 sclk rises.
- start pulsed again during busy with addr=0x77 -> ignored; the transaction finishes with the original addr; exactly one done.
- Back-to-back start asserted in the done cycle -> second transaction's ssel falls after at least CLK_DIV cycles of ssel high; both complete.
- CLK_DIV=2, rd_len=2 against the real slave with a memory model returning 0x12,0x34 -> rx_data 0x12,0x34; slave rd_addr increments once per byte.

Source files
------------

// File: rtl/spi_master_reader.sv
// SPI mode-0 read master: sends one address byte, then clocks in rd_len data
// bytes from the slave and presents each on a one-cycle rx_valid strobe.
module spi_master_reader #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       addr,
  input  logic [LEN_W-1:0] rd_len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             sclk,
  output logic             mosi,
  output logic             ssel,
  input  logic             miso
);

  // Bit counter holds 8*(rd_len+1), which needs LEN_W+4 bits at rd_len = max.
  localparam int unsigned CNT_W = LEN_W + 4;
  localparam int unsigned DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [6:0]       tx_q, tx_d;
  logic [6:0]       rxs_q, rxs_d;
  logic             addr_ph_q, addr_ph_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ssel_q, ssel_d;
  logic             rise;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bits_q     <= '0;
      tx_q       <= '0;
      rxs_q      <= '0;
      addr_ph_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ssel_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      tx_q       <= tx_d;
      rxs_q      <= rxs_d;
      addr_ph_q  <= addr_ph_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ssel_q     <= ssel_d;
    end
  end

  // Next-state, phase timing, shifting and byte delivery.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bits_d     = bits_q;
    tx_d       = tx_q;
    rxs_d      = rxs_q;
    addr_ph_d  = addr_ph_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ssel_d     = ssel_q;
    rise       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETUP;
          div_d     = '0;
          tx_d      = addr[6:0];
          bits_d    = (CNT_W'(rd_len) + CNT_W'(1)) << 3;
          addr_ph_d = 1'b1;
          busy_d    = 1'b1;
          ssel_d    = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = addr[7];
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_XFER;
          sclk_d  = 1'b1;
          rise    = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: advance mosi; the last bit's low phase is HOLD.
            sclk_d = 1'b0;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
            if (bits_q == CNT_W'(1)) begin
              state_d = S_HOLD;
            end else begin
              bits_d = bits_q - CNT_W'(1);
            end
          end else begin
            sclk_d = 1'b1;
            rise   = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_GAP;
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Rising edge: sample miso; bits_q is 1 mod 8 on the last bit of a byte.
    if (rise) begin
      rxs_d = {rxs_q[5:0], miso};
      if (bits_q[2:0] == 3'd1) begin
        if (addr_ph_q) begin
          addr_ph_d = 1'b0;
        end else begin
          rx_data_d  = {rxs_q, miso};
          rx_valid_d = 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ssel     = ssel_q;

endmodule

// File: tb/tb_spi_master_reader.sv
// Bench for spi_master_reader: two instances (CLK_DIV 4 and 2) against a
// memory-backed mode-0 slave model, with a queue-based scoreboard.
module tb_spi_master_reader;

  localparam int unsigned LEN_W   = 16;
  localparam int          TIMEOUT = 5000;

  typedef struct {
    int         inst;
    logic [7:0] addr;
    int         nbytes;
    int         busy;
  } txn_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
  } rx_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       start = '0;
  logic [7:0]       addr [2];
  logic [LEN_W-1:0] rd_len [2];
  wire  [1:0]       busy, done, rx_valid, sclk, mosi, ssel;
  wire  [7:0]       rx_data [2];

  logic [7:0] mem [256];
  txn_t       exp_txn [$];
  rx_t        exp_rx [$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min);
    n_cmp++;
    if (act < min) begin
      n_err++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int unsigned CDIV = (g == 0) ? 4 : 2;

    logic       s_miso = 1'b0;
    logic [7:0] s_rx = '0, s_tx = '0, s_addr = '0, rd_ptr = '0;
    int         s_bits = 0, s_rises = 0, s_incs = 0;
    logic       s_mosi_nz = 1'b0;
    logic       sp_sclk = 1'b0, sp_ssel = 1'b1;

    int         busy_cnt = 0, gap_cnt = 0, rx_cnt = 0, ssel_run = 1000;
    txn_t       t;
    rx_t        e;

    spi_master_reader #(.CLK_DIV(CDIV), .LEN_W(LEN_W)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start[g]),
      .addr    (addr[g]),
      .rd_len  (rd_len[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rx_data (rx_data[g]),
      .rx_valid(rx_valid[g]),
      .sclk    (sclk[g]),
      .mosi    (mosi[g]),
      .ssel    (ssel[g]),
      .miso    (s_miso)
    );

    // Mode-0 slave: address byte in, then mem[addr], mem[addr+1], ... out.
    always @(sclk[g] or ssel[g]) begin
      if (ssel[g] !== 1'b0) begin
        s_miso = 1'b0;
      end else if (sp_ssel) begin
        s_bits = 0; s_rises = 0; s_incs = 0; s_mosi_nz = 1'b0;
        s_tx = '0; s_miso = 1'b0;
      end else if (sclk[g] === 1'b1 && !sp_sclk) begin
        s_rx = {s_rx[6:0], mosi[g]};
        s_bits++;
        s_rises++;
        if (s_bits == 8) s_addr = s_rx;
        else if (s_bits > 8 && mosi[g] !== 1'b0) s_mosi_nz = 1'b1;
      end else if (sclk[g] !== 1'b1 && sp_sclk) begin
        if (s_bits % 8 == 0) begin
          if (s_bits == 8) rd_ptr = s_addr;
          else begin
            rd_ptr = rd_ptr + 8'd1;
            s_incs++;
          end
          s_tx = mem[rd_ptr];
        end else begin
          s_tx = {s_tx[6:0], 1'b0};
        end
        s_miso = s_tx[7];
      end
      sp_sclk = (sclk[g] === 1'b1);
      sp_ssel = (ssel[g] !== 1'b0);
    end

    // Monitor: pops expectations whenever rx_valid or done is presented.
    always @(negedge clk) begin
      if (!reset_n) begin
        busy_cnt = 0; gap_cnt = 0; rx_cnt = 0; ssel_run = 1000;
      end else begin
        if (busy[g]) busy_cnt++;
        if (busy[g] && ssel[g]) gap_cnt++;
        if (!ssel[g] && ssel_run > 0) check_min("ssel_high_gap", ssel_run, CDIV);
        ssel_run = ssel[g] ? ssel_run + 1 : 0;
        if (rx_valid[g]) begin
          rx_cnt++;
          if (exp_rx.size() == 0) begin
            check("rx_unexpected", 32'(rx_data[g]), 32'hFFFF_FFFF);
          end else begin
            e = exp_rx.pop_front();
            check("rx_inst", g, e.inst);
            check("rx_data", 32'(rx_data[g]), 32'(e.data));
          end
        end
        if (done[g]) begin
          if (exp_txn.size() == 0) begin
            check("done_unexpected", 32'(done[g]), 32'd0);
          end else begin
            t = exp_txn.pop_front();
            check("done_inst", g, t.inst);
            check("mosi_addr", 32'(s_addr), 32'(t.addr));
            check("sclk_rises", s_rises, 8 * (t.nbytes + 1));
            check("mosi_data_zero", 32'(s_mosi_nz), 32'd0);
            check("rx_count", rx_cnt, t.nbytes);
            check("rd_addr_incs", s_incs, t.nbytes);
            check("busy_cycles", busy_cnt, t.busy);
            check("ssel_high_before_done", gap_cnt, CDIV);
            check("ssel_at_done", 32'(ssel[g]), 32'd1);
          end
          busy_cnt = 0; gap_cnt = 0; rx_cnt = 0;
        end
      end
    end
  end

  task automatic pulse(input int g, input logic [7:0] a, input logic [15:0] len);
    @(negedge clk);
    addr[g]   = a;
    rd_len[g] = len;
    start[g]  = 1'b1;
    @(negedge clk);
    start[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (done[g] !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout inst %0d: no done after %0d cycles, required within %0d", g, n, TIMEOUT);
    end
  endtask

  task automatic go(input int g, input logic [7:0] a, input logic [15:0] len, input int busy_exp);
    exp_txn.push_back('{g, a, int'(len), busy_exp});
    pulse(g, a, len);
    wait_done(g);
  endtask

  initial begin
    int r, n, extra;
    logic p;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C; mem[8'h11] = 8'hFF; mem[8'h12] = 8'h00;
    mem[8'h01] = 8'h5A; mem[8'h33] = 8'hC3;
    mem[8'h50] = 8'h81; mem[8'h60] = 8'h42; mem[8'h61] = 8'h24;
    mem[8'h40] = 8'h12; mem[8'h41] = 8'h34;
    addr[0] = 8'h00; addr[1] = 8'h00;
    rd_len[0] = '0;  rd_len[1] = '0;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssel", 32'(ssel[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd0);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check("rst_rx_data", 32'(rx_data[0]), 32'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Address only: 0xA5, no data bytes.
    go(0, 8'hA5, 16'd0, 72);

    // Three data bytes.
    exp_rx.push_back('{0, 8'h3C});
    exp_rx.push_back('{0, 8'hFF});
    exp_rx.push_back('{0, 8'h00});
    go(0, 8'h10, 16'd3, 264);

    // Start while busy is ignored.
    exp_rx.push_back('{0, 8'hC3});
    exp_txn.push_back('{0, 8'h33, 1, 136});
    pulse(0, 8'h33, 16'd1);
    repeat (40) @(negedge clk);
    pulse(0, 8'h77, 16'd5);
    wait_done(0);
    extra = 0;
    repeat (500) begin
      @(negedge clk);
      if (done[0]) extra++;
    end
    check("single_done", extra, 0);
    check("idle_after_ignored_start", 32'(busy[0]), 32'd0);

    // Asynchronous reset after 5 sclk rises.
    pulse(0, 8'h22, 16'd2);
    r = 0; n = 0; p = 1'b0;
    while (r < 5 && n < TIMEOUT) begin
      @(negedge clk);
      if (sclk[0] && !p) r++;
      p = sclk[0];
      n++;
    end
    check("abort_rises", r, 5);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ssel", 32'(ssel[0]), 32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (done[0]) extra++;
    end
    check("abort_no_done", extra, 0);
    exp_rx.push_back('{0, 8'h5A});
    go(0, 8'h01, 16'd1, 136);

    // Back-to-back: second start asserted in the done cycle.
    exp_rx.push_back('{0, 8'h81});
    exp_rx.push_back('{0, 8'h42});
    exp_rx.push_back('{0, 8'h24});
    exp_txn.push_back('{0, 8'h50, 1, 136});
    exp_txn.push_back('{0, 8'h60, 2, 200});
    pulse(0, 8'h50, 16'd1);
    wait_done(0);
    addr[0]   = 8'h60;
    rd_len[0] = 16'd2;
    start[0]  = 1'b1;
    @(negedge clk);
    start[0]  = 1'b0;
    check("b2b_busy", 32'(busy[0]), 32'd1);
    wait_done(0);

    // CLK_DIV=2 instance.
    exp_rx.push_back('{1, 8'h12});
    exp_rx.push_back('{1, 8'h34});
    go(1, 8'h40, 16'd2, 100);

    repeat (20) @(negedge clk);
    check("rx_queue_empty", exp_rx.size(), 0);
    check("txn_queue_empty", exp_txn.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
